// File: rtl/serial_adder_pkg.sv
// Shared types and elaboration helpers for the digit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StHold
  } state_e;

  // Legal configuration: DIGIT >= 1 and DIGIT divides WIDTH.
  function automatic bit cfg_ok(int unsigned width, int unsigned digit);
    if (digit < 1) return 1'b0;
    return (width % digit) == 0;
  endfunction

  // Digit counter width, never narrower than one bit.
  function automatic int unsigned cnt_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adder_digit.sv
// Combinational DIGIT-bit ripple slice. c_msb is the carry into the top bit of the slice,
// which for the last digit is the carry into bit WIDTH-1 (used for signed overflow).
module adder_digit #(
  parameter int unsigned DIGIT = 4
) (
  input  logic [DIGIT-1:0] a_d,
  input  logic [DIGIT-1:0] b_d,
  input  logic             c_in,
  output logic [DIGIT-1:0] s_d,
  output logic             c_out,
  output logic             c_msb
);

  logic [DIGIT:0] c;

  // Bitwise ripple through the slice
  always_comb begin
    c    = '0;
    s_d  = '0;
    c[0] = c_in;
    for (int i = 0; i < int'(DIGIT); i++) begin
      s_d[i]  = a_d[i] ^ b_d[i] ^ c[i];
      c[i+1]  = (a_d[i] & b_d[i]) | (a_d[i] & c[i]) | (b_d[i] & c[i]);
    end
  end

  assign c_out = c[DIGIT];
  assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder: accepts a, b, carry_in in IDLE, adds DIGIT bits per cycle in RUN,
// presents sum/carry_out in HOLD until the consumer takes them.
// Optional feature: define SERIAL_ADDER_OVF_EN to add the signed overflow output.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             overflow
`endif
);

  // Guard the division so a bad DIGIT reaches the fatal check rather than a divide-by-zero.
  localparam int unsigned N    = (DIGIT == 0) ? 1 : WIDTH / DIGIT;
  localparam int unsigned CntW = cnt_width(N);

  if (!cfg_ok(WIDTH, DIGIT)) begin : gen_cfg_fatal
    $fatal(1, "serial_adder: DIGIT must be >= 1 and divide WIDTH");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [DIGIT-1:0] a_dig, b_dig, s_dig;
  logic             c_out, c_msb;
  logic             last;
  int unsigned      idx;

  assign idx   = cnt_q * DIGIT;
  assign a_dig = a_q[idx +: DIGIT];
  assign b_dig = b_q[idx +: DIGIT];
  assign last  = (cnt_q == CntW'(N - 1));

  adder_digit #(
    .DIGIT (DIGIT)
  ) u_adder_digit (
    .a_d   (a_dig),
    .b_d   (b_dig),
    .c_in  (carry_q),
    .s_d   (s_dig),
    .c_out (c_out),
    .c_msb (c_msb)
  );

  // Next-state logic: accept in IDLE, one digit per RUN cycle, wait for consumer in HOLD
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = carry_in;
          sum_d   = '0;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        sum_d[idx +: DIGIT] = s_dig;
        carry_d             = c_out;
        cnt_d               = cnt_q + 1'b1;
        if (last) state_d = StHold;
      end
      StHold: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StHold);
  assign sum       = sum_q;
  assign carry_out = carry_q;

`ifdef SERIAL_ADDER_OVF_EN
  logic ovf_q;

  // Overflow captured on the final digit, cleared on accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (state_q == StIdle && in_valid) begin
      ovf_q <= 1'b0;
    end else if (state_q == StRun && last) begin
      ovf_q <= c_msb ^ c_out;
    end
  end

  assign overflow = ovf_q;
`else
  logic unused_c_msb;
  assign unused_c_msb = c_msb;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed vector table, multi-cycle corner cases,
// an 8/8 single-digit instance and a randomised run against an a+b+carry_in model.
module tb_serial_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] op_a, op_b, sum;
  logic        op_ci, carry_out;
  logic        in8_valid, in8_ready, out8_valid, out8_ready;
  logic [7:0]  a8, b8, sum8;
  logic        ci8, co8;
`ifdef SERIAL_ADDER_OVF_EN
  logic        overflow, ovf8;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_adder #(
    .WIDTH (16),
    .DIGIT (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (op_a),
    .b         (op_b),
    .carry_in  (op_ci),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .overflow  (overflow)
`endif
  );

  serial_adder #(
    .WIDTH (8),
    .DIGIT (8)
  ) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in8_valid),
    .in_ready  (in8_ready),
    .a         (a8),
    .b         (b8),
    .carry_in  (ci8),
    .out_valid (out8_valid),
    .out_ready (out8_ready),
    .sum       (sum8),
    .carry_out (co8)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .overflow  (ovf8)
`endif
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic [15:0] sum;
    logic        co;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Present operands for one accepting edge, then scramble them to prove they are not reused.
  task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic ci);
    in_valid = 1'b1;
    op_a     = a;
    op_b     = b;
    op_ci    = ci;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op_a     = 16'($urandom);
    op_b     = 16'($urandom);
    op_ci    = 1'($urandom);
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) begin
      checks++;
      errors++;
      $display("FAIL result_timeout: got out_valid=0 after %0d cycles, expected 1", lat);
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    int          lat;
    int          hits[$];
    int          n;
    logic        held;
    logic [15:0] ra, rb, hold_sum;
    logic        rc;
    logic [16:0] exp17;

    vecs[0] = '{16'h0003, 16'h0005, 1'b0, 16'h0008, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1};
    vecs[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    vecs[3] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
    vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
    vecs[5] = '{16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0};
    vecs[6] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0};
    vecs[7] = '{16'hABCD, 16'h1111, 1'b1, 16'hBCDF, 1'b0};
    vecs[8] = '{16'hF00F, 16'h0FF1, 1'b0, 16'h0000, 1'b1};

    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; op_a = '0; op_b = '0; op_ci = 1'b0;
    in8_valid = 1'b0; out8_ready = 1'b0; a8 = '0; b8 = '0; ci8 = 1'b0;

    // Reset state
    #2;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_carry_out", 32'(carry_out), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vector table
    for (int i = 0; i < 9; i++) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].ci);
      check("busy_in_ready", 32'(in_ready), 32'd0);
      wait_result(lat);
      check("vec_latency", 32'(lat), 32'd4);
      check("vec_sum", 32'(sum), 32'(vecs[i].sum));
      check("vec_carry_out", 32'(carry_out), 32'(vecs[i].co));
      consume();
      check("vec_back_idle", 32'(in_ready), 32'd1);
    end

`ifdef SERIAL_ADDER_OVF_EN
    start_op(16'h7FFF, 16'h0001, 1'b0);
    wait_result(lat);
    check("ovf_pos", 32'(overflow), 32'd1);
    consume();
    start_op(16'h8000, 16'h8000, 1'b0);
    wait_result(lat);
    check("ovf_neg", 32'(overflow), 32'd1);
    consume();
    start_op(16'h0003, 16'h0005, 1'b0);
    wait_result(lat);
    check("ovf_none", 32'(overflow), 32'd0);
    consume();
`endif

    // HOLD stall: result stable, new operands ignored
    start_op(16'h1234, 16'h0001, 1'b0);
    wait_result(lat);
    hold_sum = sum;
    check("hold_sum", 32'(hold_sum), 32'h1235);
    in_valid = 1'b1; op_a = 16'h5555; op_b = 16'h5555; op_ci = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("hold_stable_sum", 32'(sum), 32'(hold_sum));
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    check("hold_release_idle", 32'(in_ready), 32'd1);
    check("hold_release_ov", 32'(out_valid), 32'd0);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid || !in_ready) n++;
    end
    check("hold_no_phantom_op", 32'(n), 32'd0);

    // Reset during RUN cycle 2 aborts the operation
    start_op(16'h0FF9, 16'h0008, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort_sum", 32'(sum), 32'd0);
    check("abort_carry_out", 32'(carry_out), 32'd0);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) n++;
    end
    check("abort_no_result", 32'(n), 32'd0);
    start_op(16'h0FF9, 16'h0008, 1'b0);
    wait_result(lat);
    check("abort_next_sum", 32'(sum), 32'h1001);
    check("abort_next_co", 32'(carry_out), 32'd0);
    consume();

    // Throughput with out_ready held high: one accept every N+2 = 6 cycles
    in_valid = 1'b1; op_a = 16'h0001; op_b = 16'h0002; op_ci = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (in_ready) hits.push_back(c);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("tput_accepts", 32'(hits.size()), 32'd4);
    if (hits.size() >= 2) check("tput_period", 32'(hits[1] - hits[0]), 32'd6);
    out_ready = 1'b0;
    wait_result(lat);
    check("tput_sum", 32'(sum), 32'h0003);
    consume();

    // Single-digit instance: latency 1
    in8_valid = 1'b1; a8 = 8'hF0; b8 = 8'h20; ci8 = 1'b0;
    @(posedge clk); #1;
    in8_valid = 1'b0; a8 = 8'h00; b8 = 8'h00;
    check("d8_busy", 32'(out8_valid), 32'd0);
    @(posedge clk); #1;
    check("d8_out_valid", 32'(out8_valid), 32'd1);
    check("d8_sum", 32'(sum8), 32'h10);
    check("d8_carry_out", 32'(co8), 32'd1);
`ifdef SERIAL_ADDER_OVF_EN
    check("d8_overflow", 32'(ovf8), 32'd0);
`endif
    out8_ready = 1'b1;
    @(posedge clk); #1;
    out8_ready = 1'b0;
    check("d8_idle", 32'(in8_ready), 32'd1);

    // Randomised operations with random out_ready
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      exp17 = {1'b0, ra} + {1'b0, rb} + 17'(rc);
      out_ready = 1'($urandom);
      start_op(ra, rb, rc);
      out_ready = 1'($urandom);
      wait_result(lat);
      check("rand_sum", 32'(sum), 32'(exp17[15:0]));
      check("rand_carry_out", 32'(carry_out), 32'(exp17[16]));
`ifdef SERIAL_ADDER_OVF_EN
      check("rand_overflow", 32'(overflow),
            32'((ra[15] == rb[15]) && (exp17[15] != ra[15])));
`endif
      n = 0;
      do begin
        out_ready = 1'($urandom);
        held = out_ready;
        @(posedge clk); #1;
        n++;
      end while (!held && n < 20);
      if (!held) consume();
      out_ready = 1'b0;
      if (out_valid) begin
        checks++;
        errors++;
        $display("FAIL rand_release: got out_valid=1, expected 0");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
